// File: rtl/riscv_exu_issue.sv
// riscv_exu_issue: in-order issue to ALU/MDU with rd hazard stall and shared writeback port arbitration
module riscv_exu_issue #(
  parameter int SEQ_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic             in_mdu,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  output logic             alu_vld,
  output logic             mdu_start,
  input  logic             mdu_done,
  input  logic [31:0]      mdu_wr_data,
  input  logic             alu_wr_en,
  input  logic [4:0]       alu_wr,
  input  logic [31:0]      alu_wr_data,
  output logic             reg_wr_en,
  output logic [4:0]       reg_wr,
  output logic [31:0]      reg_wr_data,
  output logic [SEQ_W-1:0] issue_seq,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, MDU_BUSY, MDU_HOLD} state_t;
  state_t state;
  logic [4:0] busy_rd;
  logic [31:0] hold;
  logic [SEQ_W-1:0] seq;
  logic hazard, mdu_wb, hold_wb;
  always_comb begin
    hazard = busy_rd != 5'd0 && (in_rs1 == busy_rd || in_rs2 == busy_rd || in_rd == busy_rd);
    in_rdy = reset ? 1'b0 : state == IDLE ? 1'b1 : state == MDU_BUSY ? (!in_mdu && !hazard && !mdu_done) : 1'b0;
    alu_vld = in_vld && in_rdy && !in_mdu;
    mdu_start = in_vld && in_rdy && in_mdu;
    mdu_wb = state == MDU_BUSY && mdu_done;
    hold_wb = state == MDU_HOLD;
    // ALU always owns the port when it writes; MDU results wait in hold
    reg_wr_en = !reset && (alu_wr_en || mdu_wb || hold_wb);
    reg_wr = alu_wr_en ? alu_wr : busy_rd;
    reg_wr_data = alu_wr_en ? alu_wr_data : hold_wb ? hold : mdu_wr_data;
    issue_seq = seq;
    busy = state != IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy_rd <= 5'd0;
      hold <= 32'd0;
      seq <= '0;
    end else begin
      if (in_vld && in_rdy) seq <= seq + SEQ_W'(1);
      if (mdu_start) begin
        busy_rd <= in_rd;
        state <= MDU_BUSY;
      end else if (mdu_wb) begin
        hold <= mdu_wr_data;
        state <= alu_wr_en ? MDU_HOLD : IDLE;
      end else if (hold_wb && !alu_wr_en) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: doc/riscv_exu_issue.md
RISCV_EXU_ISSUE -- requirements
Module: riscv_exu_issue

Interface
REQ-001 SHALL have parameter SEQ_W, default 64, width of the instruction order counter.
REQ-002 SHALL have port clock  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port in_vld  in  1  decoded instruction valid.
REQ-005 SHALL have port in_rdy  out  1  instruction accepted this cycle when in_vld && in_rdy.
REQ-006 SHALL have port in_mdu  in  1  instruction targets the multi-cycle MUL/DIV unit (MDU); 0 = ALU.
REQ-007 SHALL have ports in_rd, in_rs1, in_rs2  in  5 each  destination and source register indices.
REQ-008 SHALL have port alu_vld  out  1  ALU issue strobe.
REQ-009 SHALL have port mdu_start  out  1  MDU issue strobe.
REQ-010 SHALL have port mdu_done  in  1  MDU result valid, single-cycle pulse.
REQ-011 SHALL have port mdu_wr_data  in  32  MDU result, valid with mdu_done.
REQ-012 SHALL have ports alu_wr_en in 1, alu_wr in 5, alu_wr_data in 32  ALU writeback request, one cycle after alu_vld.
REQ-013 SHALL have ports reg_wr_en out 1, reg_wr out 5, reg_wr_data out 32  single register-file write port.
REQ-014 SHALL have port issue_seq  out  SEQ_W  order number of the instruction accepted this cycle.
REQ-015 SHALL have port busy  out  1  MDU operation outstanding (state != IDLE).

Function
REQ-016 SHALL implement states IDLE, MDU_BUSY, MDU_HOLD.
REQ-017 SHALL define hazard = busy_rd != 0 && (in_rs1 == busy_rd || in_rs2 == busy_rd || in_rd == busy_rd), where busy_rd is the rd of the outstanding MDU op.
REQ-018 SHALL drive in_rdy = 1 in IDLE; in MDU_BUSY in_rdy = !in_mdu && !hazard && !mdu_done; in MDU_HOLD in_rdy = 0.
REQ-019 SHALL assert alu_vld = in_vld && in_rdy && !in_mdu and mdu_start = in_vld && in_rdy && in_mdu, combinationally, same cycle as acceptance.
REQ-020 SHALL on mdu_start capture busy_rd <= in_rd and transition IDLE -> MDU_BUSY.
REQ-021 SHALL drive issue_seq = current counter value; counter increments by 1 per accepted instruction, wraps modulo 2^SEQ_W.
REQ-022 SHALL pass ALU writeback through combinationally: when alu_wr_en, reg_wr_en=1, reg_wr=alu_wr, reg_wr_data=alu_wr_data.
REQ-023 SHALL in MDU_BUSY on mdu_done with alu_wr_en=0: write mdu_wr_data to busy_rd same cycle, next state IDLE.
REQ-024 SHALL in MDU_BUSY on mdu_done with alu_wr_en=1: give port to ALU, latch mdu_wr_data into hold register, next state MDU_HOLD.
REQ-025 SHALL in MDU_HOLD write hold data to busy_rd on the first cycle alu_wr_en=0, then go IDLE; remain MDU_HOLD while alu_wr_en=1.
REQ-026 SHALL ignore mdu_done in IDLE and MDU_HOLD.
REQ-027 SHALL treat rd=0 like any other index for writeback; x0 suppression belongs to the register file; busy_rd=0 never raises hazard.
REQ-028 SHALL never assert reg_wr_en for two sources in one cycle; ALU always has priority.
REQ-029 SHALL in IDLE with in_mdu=1 and in_vld=1 accept immediately (no hazard check needed).

Reset
REQ-030 SHALL on reset force state IDLE, busy_rd=0, hold register discarded, counter=0.
REQ-031 SHALL while reset=1 drive in_rdy=0, alu_vld=0, mdu_start=0, reg_wr_en=0.
REQ-032 SHALL drop an in-flight MDU op on reset; a later mdu_done is ignored per REQ-026.

Verification
REQ-033 Back-to-back ALU ops rd=1,2,3 -> in_rdy held 1, alu_vld 3 cycles, issue_seq 0,1,2.
REQ-034 MDU op rd=5 then ALU op rs1=5 -> ALU held (in_rdy=0) until mdu_done; reg_wr=5 written with MDU data, ALU accepted next cycle.
REQ-035 MDU op rd=5, ALU op rd=6 rs1=1 rs2=2 issued during MDU_BUSY, mdu_done coincident with alu_wr_en -> cycle N writes r6, cycle N+1 writes r5 with latched data.
REQ-036 Second MDU op while MDU_BUSY -> in_rdy=0 until IDLE, then mdu_start.
REQ-037 Reset asserted in MDU_BUSY, then mdu_done=1 -> no reg_wr_en, busy=0, next issue_seq=0.
REQ-038 SEQ_W=4, 17 accepted ops -> issue_seq wraps 15 -> 0, 17th op issue_seq=0.
